mem_arbiter: RTL and testbench

Single-port memory arbiter for the SoC's shared 512-byte byte-addressed memory. It sits between the core's instruction-fetch port and load/store data port and the memory macro. It grants one requester at a time over a valid/ready handshake and sequences the registered-read memory access. It returns a one-cycle response pulse with read data or an error flag.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto the shared single-port memory.
// One access in flight at a time: accept, issue to memory, then a one-cycle response.
module mem_arbiter #(
    parameter int MEM_SIZE     = 512,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_starve;
    logic          w_gnt_if, w_gnt_d, w_acc, w_err, w_dwr, w_good_rd;
    logic [31:0]   w_addr;
    logic          r_port, r_we, r_err;
    logic          r_mem_en, r_mem_we;
    logic [3:0]    r_mem_wstrb;
    logic [31:0]   r_mem_addr, r_mem_wdata;
    logic          r_if_rsp, r_d_rsp, r_if_err, r_d_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_gnt_if     = 1'b0;
        w_gnt_d      = 1'b0;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt_if     = if_req_valid && (!d_req_valid || r_starve == CW'(STARVE_LIMIT));
                w_gnt_d      = d_req_valid && !w_gnt_if;
                if_req_ready = w_gnt_if && !rst;
                d_req_ready  = w_gnt_d && !rst;
                if (if_req_ready || d_req_ready) w_next = ISSUE;
            end
            ISSUE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_acc  = if_req_ready || d_req_ready;
    assign w_addr = w_gnt_if ? if_addr : d_addr;
    assign w_dwr  = w_gnt_d && d_we;
    assign w_err  = (w_addr[1:0] != 2'b00) || (w_addr > 32'(MEM_SIZE - 4));

    // The mem_* registers double as the request latches for address and write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve    <= '0;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0;
            r_mem_addr  <= 32'b0;
            r_mem_wdata <= 32'b0;
            r_if_rsp    <= 1'b0;
            r_d_rsp     <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0;
            r_if_rsp    <= 1'b0;
            r_d_rsp     <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;
            if (r_state == IDLE) begin
                if (!if_req_valid || w_gnt_if)
                    r_starve <= '0;
                else if (w_gnt_d && r_starve != CW'(STARVE_LIMIT))
                    r_starve <= r_starve + CW'(1);
            end
            if (w_acc) begin
                r_port      <= w_gnt_d;
                r_we        <= w_dwr;
                r_err       <= w_err;
                r_mem_en    <= !w_err;
                r_mem_we    <= w_dwr;
                r_mem_wstrb <= w_dwr ? d_wstrb : 4'b0;
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_gnt_d ? d_wdata : 32'b0;
            end
            if (r_state == ISSUE) begin
                r_if_rsp <= !r_port;
                r_d_rsp  <= r_port;
                r_if_err <= !r_port && r_err;
                r_d_err  <= r_port && r_err;
            end
        end
    end

    // Read data comes straight from the macro's output register during RESP.
    assign w_good_rd = (r_state == RESP) && !r_we && !r_err;

    assign if_rsp_valid = r_if_rsp;
    assign d_rsp_valid  = r_d_rsp;
    assign if_err       = r_if_err;
    assign d_err        = r_d_err;
    assign if_rdata     = (w_good_rd && !r_port) ? mem_rdata : 32'b0;
    assign d_rdata      = (w_good_rd && r_port) ? mem_rdata : 32'b0;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_wstrb    = r_mem_wstrb;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, contention/reset sequences, and a
// randomized run against a cycle-count reference model with its own memory image.
module tb_mem_arbiter;
    localparam int MEM_SIZE = 512;
    localparam int LIMIT    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_err;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'b0;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.MEM_SIZE(MEM_SIZE), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro: registered read, byte-strobed write.
    logic [31:0] tb_mem [128];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) tb_mem[i] <= 32'b0;
            tb_mem[0]   <= 32'h0000_0013;
            tb_mem[127] <= 32'hCAFE_0001;
            mem_init    <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) tb_mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= tb_mem[mem_addr[8:2]];
            end
        end
    end

    logic [31:0] ref_mem [128];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_acc(input logic [31:0] a, input bit we, input logic [3:0] st,
                             input logic [31:0] wd, output bit err, output logic [31:0] rd);
        err = (a % 4 != 0) || (a > MEM_SIZE - 4);
        rd  = 32'b0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) ref_mem[a / 4][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = ref_mem[a / 4];
            end
        end
    endtask

    typedef struct {
        bit          port;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  st;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
    } vec_t;

    // Called at a negedge with the DUT idle; returns at the negedge of T+3.
    task automatic txn(input vec_t v, input string nm, output int waits);
        bit          merr;
        logic [31:0] mrd;
        bit          we_eff;
        we_eff = v.port && v.we;
        if (v.port) begin
            d_req_valid = 1'b1; d_addr = v.addr; d_we = v.we; d_wstrb = v.st; d_wdata = v.wd;
        end else begin
            if_req_valid = 1'b1; if_addr = v.addr;
        end
        waits = 0;
        #1;
        while (!(v.port ? d_req_ready : if_req_ready) && waits < 10) begin
            @(negedge clk); #1; waits++;
        end
        if (waits >= 10) begin
            chk({nm, "_accept_timeout"}, 32'(waits), 32'd0);
            if_req_valid = 1'b0; d_req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        model_acc(v.addr, we_eff, v.st, v.wd, merr, mrd);
        @(negedge clk);
        chk({nm, "_mem_en"}, 32'(mem_en), 32'(!v.err));
        if (!v.err) begin
            chk({nm, "_mem_addr"}, mem_addr, v.addr);
            chk({nm, "_mem_we"}, 32'(mem_we), 32'(we_eff));
            chk({nm, "_mem_wstrb"}, 32'(mem_wstrb), we_eff ? 32'(v.st) : 32'd0);
            if (we_eff) chk({nm, "_mem_wdata"}, mem_wdata, v.wd);
        end
        chk({nm, "_early_rsp"}, 32'(if_rsp_valid | d_rsp_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_if_rsp"}, 32'(if_rsp_valid), 32'(!v.port));
        chk({nm, "_d_rsp"}, 32'(d_rsp_valid), 32'(v.port));
        chk({nm, "_rdata"}, v.port ? d_rdata : if_rdata, v.rd);
        chk({nm, "_err"}, 32'(v.port ? d_err : if_err), 32'(v.err));
        @(negedge clk);
        chk({nm, "_rsp_done"}, 32'(if_rsp_valid | d_rsp_valid), 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = int'($urandom % 10);
        if (r == 0) return (($urandom % 16) * 4) + 1 + ($urandom % 3);
        if (r == 1) return 32'h200 + ($urandom % 4) * 4;
        if (r == 2) return 32'h1FC;
        return ($urandom % 16) * 4;
    endfunction

    typedef struct {
        bit          port;
        logic [31:0] rd;
        bit          err;
        int          due;
    } exp_rsp_t;

    vec_t tv [14];

    initial begin
        int       w, ng, last;
        exp_rsp_t q[$];
        exp_rsp_t e;
        int       busy, denials;
        bit       gf, gd, acc_if, acc_d, idle, merr;
        logic [31:0] mrd;

        tv[0]  = '{0, 32'h0,        0, 4'b0000, 32'h0,         0, 32'h0000_0013};
        tv[1]  = '{1, 32'h10,       1, 4'b0011, 32'hDEAD_BEEF, 0, 32'h0};
        tv[2]  = '{1, 32'h10,       0, 4'b0000, 32'h0,         0, 32'h0000_BEEF};
        tv[3]  = '{1, 32'h10,       1, 4'b1000, 32'h1122_3344, 0, 32'h0};
        tv[4]  = '{1, 32'h10,       0, 4'b0000, 32'h0,         0, 32'h1100_BEEF};
        tv[5]  = '{1, 32'h6,        0, 4'b0000, 32'h0,         1, 32'h0};
        tv[6]  = '{1, 32'h200,      0, 4'b0000, 32'h0,         1, 32'h0};
        tv[7]  = '{0, 32'h1FC,      0, 4'b0000, 32'h0,         0, 32'hCAFE_0001};
        tv[8]  = '{1, 32'h14,       1, 4'b0000, 32'hFFFF_FFFF, 0, 32'h0};
        tv[9]  = '{1, 32'h14,       0, 4'b0000, 32'h0,         0, 32'h0};
        tv[10] = '{1, 32'h1FE,      1, 4'b1111, 32'h5555_5555, 1, 32'h0};
        tv[11] = '{1, 32'h1FC,      0, 4'b0000, 32'h0,         0, 32'hCAFE_0001};
        tv[12] = '{0, 32'h3,        0, 4'b0000, 32'h0,         1, 32'h0};
        tv[13] = '{1, 32'hFFFF_FFFC, 0, 4'b0000, 32'h0,        1, 32'h0};

        for (int i = 0; i < 128; i++) ref_mem[i] = 32'b0;
        ref_mem[0]   = 32'h0000_0013;
        ref_mem[127] = 32'hCAFE_0001;

        rst = 1'b1;
        if_req_valid = 1'b0; if_addr = 32'b0;
        d_req_valid = 1'b0; d_addr = 32'b0; d_we = 1'b0; d_wstrb = 4'b0; d_wdata = 32'b0;
        repeat (3) @(negedge clk);
        chk("rst_if_rsp", 32'(if_rsp_valid), 32'd0);
        chk("rst_d_rsp", 32'(d_rsp_valid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) txn(tv[i], $sformatf("vec%0d", i), w);

        // Both ports hold requests: data four times, then fetch, with 3-cycle spacing.
        ng = 0; last = -1;
        if_req_valid = 1'b1; if_addr = 32'h0;
        d_req_valid = 1'b1; d_addr = 32'h10; d_we = 1'b0;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            #1;
            if (if_req_ready || d_req_ready) begin
                chk($sformatf("cont_gnt%0d_fetch", ng), 32'(if_req_ready), 32'(ng % 5 == 4));
                chk($sformatf("cont_gnt%0d_data", ng), 32'(d_req_ready), 32'(ng % 5 != 4));
                if (ng > 0) chk($sformatf("cont_gap%0d", ng), 32'(c - last), 32'd3);
                last = c; ng++;
            end
            if (if_rsp_valid && d_rsp_valid) chk("cont_dual_rsp", 32'd1, 32'd0);
            @(negedge clk);
        end
        chk("cont_grants", 32'(ng), 32'd10);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during the ISSUE cycle of a read aborts it.
        d_req_valid = 1'b1; d_addr = 32'h1FC; d_we = 1'b0;
        #1;
        chk("rstmid_ready", 32'(d_req_ready), 32'd1);
        @(posedge clk); #1;
        d_req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_issue_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        chk("rstmid_d_rsp", 32'(d_rsp_valid), 32'd0);
        chk("rstmid_if_rsp", 32'(if_rsp_valid), 32'd0);
        chk("rstmid_mem_en", 32'(mem_en), 32'd0);
        chk("rstmid_rdata", d_rdata, 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        txn('{1, 32'h1FC, 0, 4'b0000, 32'h0, 0, 32'hCAFE_0001}, "rstmid_after", w);
        chk("rstmid_first_idle_accept", 32'(w), 32'd0);

        // Randomized traffic against the reference model.
        busy = 0; denials = 0; acc_if = 1'b0; acc_d = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rnd_if_rsp", 32'(if_rsp_valid), 32'(!e.port));
                chk("rnd_d_rsp", 32'(d_rsp_valid), 32'(e.port));
                chk("rnd_rdata", e.port ? d_rdata : if_rdata, e.rd);
                chk("rnd_err", 32'(e.port ? d_err : if_err), 32'(e.err));
            end else begin
                chk("rnd_no_rsp", 32'(if_rsp_valid | d_rsp_valid), 32'd0);
            end
            if (!if_req_valid || acc_if) begin
                if_req_valid = ($urandom % 3) != 0;
                if_addr = rnd_addr();
            end
            if (!d_req_valid || acc_d) begin
                d_req_valid = ($urandom % 3) != 0;
                d_addr = rnd_addr();
                d_we = $urandom % 2;
                d_wstrb = 4'($urandom);
                d_wdata = $urandom;
            end
            #1;
            idle = (busy == 0);
            if (!idle) busy--;
            gf = idle && if_req_valid && (!d_req_valid || denials == LIMIT);
            gd = idle && d_req_valid && !gf;
            chk("rnd_if_ready", 32'(if_req_ready), 32'(gf));
            chk("rnd_d_ready", 32'(d_req_ready), 32'(gd));
            if (idle) begin
                if (!if_req_valid || gf) denials = 0;
                else if (denials < LIMIT) denials++;
            end
            acc_if = gf; acc_d = gd;
            if (gf || gd) begin
                if (gf) model_acc(if_addr, 1'b0, 4'b0, 32'b0, merr, mrd);
                else    model_acc(d_addr, d_we, d_wstrb, d_wdata, merr, mrd);
                q.push_back('{gd, mrd, merr, cyc + 2});
                busy = 2;
            end
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        chk("rnd_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
